// File: rtl/bsg_counter_pkg.sv
// Shared types for the dynamic-limit step counter family.
package bsg_counter_pkg;

  typedef enum logic {e_counter_wrap, e_counter_saturate} bsg_counter_mode_e;

  localparam bsg_counter_mode_e CounterModeDefault = e_counter_wrap;

endpackage

// File: rtl/bsg_counter_limit_next.sv
// Combinational next-value / wrap-flag computation for one enabled counter update.
// All comparisons run at width_p+1 bits so an all-ones limit never truncates.
module bsg_counter_limit_next
  import bsg_counter_pkg::*;
#(
  parameter int unsigned width_p      = 16,
  parameter int unsigned step_width_p = 4
) (
  input  logic [width_p-1:0]      counter_i,
  input  logic [step_width_p-1:0] step_i,
  input  logic [width_p-1:0]      limit_i,
  input  bsg_counter_mode_e       mode_i,
  output logic [width_p-1:0]      next_o,
  output logic                    wrap_o
);

  logic [width_p:0] cnt_ext, lim_ext, sum, lim1, wrap_val;

  assign cnt_ext  = {1'b0, counter_i};
  assign lim_ext  = {1'b0, limit_i};
  assign sum      = cnt_ext + (width_p+1)'(step_i);
  assign lim1     = lim_ext + (width_p+1)'(1);
  assign wrap_val = sum - lim1;

  always_comb begin
    next_o = counter_i;
    wrap_o = 1'b0;
    if (step_i != '0) begin
      if (cnt_ext > lim_ext) begin
        wrap_o = 1'b1;
        next_o = (mode_i == e_counter_saturate) ? limit_i : '0;
      end else if (sum > lim_ext) begin
        wrap_o = 1'b1;
        if (mode_i == e_counter_saturate) begin
          next_o = limit_i;
        end else begin
          // A step larger than the whole range cannot land in range; restart at 0.
          next_o = (wrap_val <= lim_ext) ? wrap_val[width_p-1:0] : '0;
        end
      end else begin
        next_o = sum[width_p-1:0];
      end
    end
  end

endmodule

// File: rtl/bsg_counter_dynamic_limit_step.sv
// Step counter with run-time inclusive limit, wrap/saturate mode, clear and wrap pulse.
// Optional saturating wrap-event counter when BSG_COUNTER_WRAP_COUNT_EN is defined.
module bsg_counter_dynamic_limit_step
  import bsg_counter_pkg::*;
#(
  parameter int unsigned       width_p      = 16,
  parameter int unsigned       step_width_p = 4,
  parameter bsg_counter_mode_e mode_p       = CounterModeDefault
`ifdef BSG_COUNTER_WRAP_COUNT_EN
  ,
  parameter int unsigned       wrap_count_width_p = 8
`endif
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    en_i,
  input  logic                    clear_i,
  input  logic [step_width_p-1:0] step_i,
  input  logic [width_p-1:0]      limit_i,
  output logic [width_p-1:0]      counter_o,
  output logic                    overflowed_o,
  output logic                    wrapped_o
`ifdef BSG_COUNTER_WRAP_COUNT_EN
  ,
  output logic [wrap_count_width_p-1:0] wrap_count_o
`endif
);

  logic [width_p-1:0] counter_d, counter_q, next_val;
  logic               wrapped_d, wrapped_q, next_wrap;

  bsg_counter_limit_next #(
    .width_p      (width_p),
    .step_width_p (step_width_p)
  ) u_next (
    .counter_i (counter_q),
    .step_i    (step_i),
    .limit_i   (limit_i),
    .mode_i    (mode_p),
    .next_o    (next_val),
    .wrap_o    (next_wrap)
  );

  always_comb begin
    counter_d = counter_q;
    wrapped_d = 1'b0;
    if (clear_i) begin
      counter_d = '0;
    end else if (en_i) begin
      counter_d = next_val;
      wrapped_d = next_wrap;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      counter_q <= '0;
      wrapped_q <= 1'b0;
    end else begin
      counter_q <= counter_d;
      wrapped_q <= wrapped_d;
    end
  end

  assign counter_o    = counter_q;
  assign wrapped_o    = wrapped_q;
  assign overflowed_o = (counter_q >= limit_i);

`ifdef BSG_COUNTER_WRAP_COUNT_EN
  logic [wrap_count_width_p-1:0] wrap_count_d, wrap_count_q;

  always_comb begin
    wrap_count_d = wrap_count_q;
    if (clear_i) begin
      wrap_count_d = '0;
    end else if (wrapped_d && !(&wrap_count_q)) begin
      wrap_count_d = wrap_count_q + wrap_count_width_p'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wrap_count_q <= '0;
    end else begin
      wrap_count_q <= wrap_count_d;
    end
  end

  assign wrap_count_o = wrap_count_q;
`endif

endmodule

// File: tb/tb_bsg_counter_dynamic_limit_step.sv
// Bench: wrap-mode and saturate-mode instances driven in lockstep, checked against
// directed constants and an integer reference model.
module tb_bsg_counter_dynamic_limit_step;
  import bsg_counter_pkg::*;

  logic       clk = 1'b0;
  logic       reset, en, clear;
  logic [3:0] step, limit;
  logic [3:0] dut_cnt [2];
  logic       dut_wrp [2];
  logic       dut_ovf [2];
`ifdef BSG_COUNTER_WRAP_COUNT_EN
  logic [1:0] dut_wc  [2];
`endif

  int errors = 0;
  int checks = 0;

  // Model state: index 0 = wrap instance, 1 = saturate instance.
  int mc  [2];
  int mw  [2];
  int mwc [2];

  always #5 clk = ~clk;

  bsg_counter_dynamic_limit_step #(
    .width_p (4), .step_width_p (4), .mode_p (e_counter_wrap)
`ifdef BSG_COUNTER_WRAP_COUNT_EN
    , .wrap_count_width_p (2)
`endif
  ) u_wrap (
    .clk_i (clk), .reset_i (reset), .en_i (en), .clear_i (clear), .step_i (step),
    .limit_i (limit), .counter_o (dut_cnt[0]), .overflowed_o (dut_ovf[0]),
    .wrapped_o (dut_wrp[0])
`ifdef BSG_COUNTER_WRAP_COUNT_EN
    , .wrap_count_o (dut_wc[0])
`endif
  );

  bsg_counter_dynamic_limit_step #(
    .width_p (4), .step_width_p (4), .mode_p (e_counter_saturate)
`ifdef BSG_COUNTER_WRAP_COUNT_EN
    , .wrap_count_width_p (2)
`endif
  ) u_sat (
    .clk_i (clk), .reset_i (reset), .en_i (en), .clear_i (clear), .step_i (step),
    .limit_i (limit), .counter_o (dut_cnt[1]), .overflowed_o (dut_ovf[1]),
    .wrapped_o (dut_wrp[1])
`ifdef BSG_COUNTER_WRAP_COUNT_EN
    , .wrap_count_o (dut_wc[1])
`endif
  );

  // Reference for one enabled update, straight from the counting rules.
  function automatic void ref_next(input int c, input int s, input int l, input bit sat,
                                   output int n, output int w);
    n = c;
    w = 0;
    if (s == 0) return;
    if (c > l) begin
      w = 1;
      n = sat ? l : 0;
    end else if (c + s > l) begin
      w = 1;
      if (sat) n = l;
      else begin
        n = c + s - (l + 1);
        if (n > l) n = 0;
      end
    end else begin
      n = c + s;
    end
  endfunction

  task automatic drive(input bit r, input bit c, input bit e, input int s, input int l);
    reset = r;
    clear = c;
    en    = e;
    step  = 4'(s);
    limit = 4'(l);
  endtask

  // Advance model using current inputs, then one clock; returns 1 ns after the edge.
  task automatic tick();
    int n, w;
    for (int m = 0; m < 2; m++) begin
      if (reset) begin
        mc[m] = 0; mw[m] = 0; mwc[m] = 0;
      end else if (clear) begin
        mc[m] = 0; mw[m] = 0; mwc[m] = 0;
      end else if (en) begin
        ref_next(mc[m], int'(step), int'(limit), m == 1, n, w);
        mc[m] = n;
        mw[m] = w;
        if (w == 1 && mwc[m] < 3) mwc[m]++;
      end else begin
        mw[m] = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(1, 0, 1, 3, 9);
    tick();
    tick();
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (dut_cnt[m] !== 4'd0 || dut_wrp[m] !== 1'b0 || dut_ovf[m] !== 1'b0) begin
        errors++;
        $display("FAIL reset[%0d]: got cnt=%0d wrp=%b ovf=%b want 0 0 0", m,
                 dut_cnt[m], dut_wrp[m], dut_ovf[m]);
      end
`ifdef BSG_COUNTER_WRAP_COUNT_EN
      checks++;
      if (dut_wc[m] !== 2'd0) begin
        errors++;
        $display("FAIL reset_wc[%0d]: got %0d want 0", m, dut_wc[m]);
      end
`endif
    end
  endtask

  task automatic test_step_sequence();
    int exp_c [2][5] = '{'{3, 6, 9, 2, 5}, '{3, 6, 9, 9, 9}};
    int exp_w [2][5] = '{'{0, 0, 0, 1, 0}, '{0, 0, 0, 1, 1}};
    drive(0, 1, 0, 3, 9);
    tick();
    drive(0, 0, 1, 3, 9);
    for (int i = 0; i < 5; i++) begin
      tick();
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (dut_cnt[m] !== 4'(exp_c[m][i]) || dut_wrp[m] !== exp_w[m][i][0] ||
            dut_ovf[m] !== (exp_c[m][i] == 9)) begin
          errors++;
          $display("FAIL step_seq[%0d] cycle %0d: got cnt=%0d wrp=%b ovf=%b want %0d %0d %0d",
                   m, i, dut_cnt[m], dut_wrp[m], dut_ovf[m], exp_c[m][i], exp_w[m][i],
                   exp_c[m][i] == 9);
        end
      end
    end
  endtask

  task automatic test_all_ones_limit();
    int pulses = 0;
    drive(0, 1, 0, 1, 15);
    tick();
    drive(0, 0, 1, 1, 15);
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (dut_wrp[0] === 1'b1) pulses++;
      checks++;
      if (dut_cnt[0] !== 4'(i % 16) || dut_wrp[0] !== (i == 16)) begin
        errors++;
        $display("FAIL all_ones cycle %0d: got cnt=%0d wrp=%b want %0d %0d", i,
                 dut_cnt[0], dut_wrp[0], i % 16, i == 16);
      end
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL all_ones_pulses: got %0d want 1", pulses);
    end
  endtask

  task automatic test_lower_limit();
    int exp_c [2] = '{0, 5};
    drive(0, 1, 0, 1, 15);
    tick();
    drive(0, 0, 1, 1, 15);
    repeat (8) tick();
    drive(0, 0, 1, 1, 5);
    #1;
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (dut_cnt[m] !== 4'd8 || dut_ovf[m] !== 1'b1) begin
        errors++;
        $display("FAIL lower_limit_ovf[%0d]: got cnt=%0d ovf=%b want 8 1", m,
                 dut_cnt[m], dut_ovf[m]);
      end
    end
    tick();
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (dut_cnt[m] !== 4'(exp_c[m]) || dut_wrp[m] !== 1'b1) begin
        errors++;
        $display("FAIL lower_limit[%0d]: got cnt=%0d wrp=%b want %0d 1", m,
                 dut_cnt[m], dut_wrp[m], exp_c[m]);
      end
    end
  endtask

  task automatic test_clear_and_reset();
    drive(0, 1, 0, 7, 15);
    tick();
    drive(0, 0, 1, 7, 15);
    tick();
    drive(0, 1, 1, 7, 15);
    tick();
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (dut_cnt[m] !== 4'd0 || dut_wrp[m] !== 1'b0) begin
        errors++;
        $display("FAIL clear[%0d]: got cnt=%0d wrp=%b want 0 0", m, dut_cnt[m], dut_wrp[m]);
      end
    end
    drive(0, 0, 1, 7, 15);
    tick();
    drive(1, 0, 1, 7, 15);
    tick();
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (dut_cnt[m] !== 4'd0 || dut_wrp[m] !== 1'b0) begin
        errors++;
        $display("FAIL mid_reset[%0d]: got cnt=%0d wrp=%b want 0 0", m,
                 dut_cnt[m], dut_wrp[m]);
      end
`ifdef BSG_COUNTER_WRAP_COUNT_EN
      checks++;
      if (dut_wc[m] !== 2'd0) begin
        errors++;
        $display("FAIL mid_reset_wc[%0d]: got %0d want 0", m, dut_wc[m]);
      end
`endif
    end
  endtask

  task automatic test_limit_zero();
    int exp_wc [5] = '{1, 2, 3, 3, 3};
    drive(0, 1, 0, 1, 0);
    tick();
    drive(0, 0, 1, 1, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (dut_cnt[m] !== 4'd0 || dut_wrp[m] !== 1'b1 || dut_ovf[m] !== 1'b1) begin
          errors++;
          $display("FAIL limit_zero[%0d] cycle %0d: got cnt=%0d wrp=%b ovf=%b want 0 1 1",
                   m, i, dut_cnt[m], dut_wrp[m], dut_ovf[m]);
        end
`ifdef BSG_COUNTER_WRAP_COUNT_EN
        checks++;
        if (dut_wc[m] !== 2'(exp_wc[i])) begin
          errors++;
          $display("FAIL limit_zero_wc[%0d] cycle %0d: got %0d want %0d", m, i,
                   dut_wc[m], exp_wc[i]);
        end
`else
        if (exp_wc[i] < 0) $display("unreachable");
`endif
      end
    end
  endtask

  task automatic test_random();
    int lim = 10;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) lim = $urandom_range(0, 15);
      drive($urandom_range(0, 39) == 0, $urandom_range(0, 15) == 0,
            $urandom_range(0, 3) != 0,
            ($urandom_range(0, 1) == 1) ? $urandom_range(0, 3) : $urandom_range(0, 15), lim);
      tick();
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (dut_cnt[m] !== 4'(mc[m]) || dut_wrp[m] !== mw[m][0] ||
            dut_ovf[m] !== (mc[m] >= lim)) begin
          errors++;
          $display("FAIL random[%0d] iter %0d: got cnt=%0d wrp=%b ovf=%b want %0d %0d %0d",
                   m, i, dut_cnt[m], dut_wrp[m], dut_ovf[m], mc[m], mw[m], mc[m] >= lim);
        end
`ifdef BSG_COUNTER_WRAP_COUNT_EN
        checks++;
        if (dut_wc[m] !== 2'(mwc[m])) begin
          errors++;
          $display("FAIL random_wc[%0d] iter %0d: got %0d want %0d", m, i, dut_wc[m], mwc[m]);
        end
`endif
      end
    end
  endtask

  initial begin
    drive(1, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    test_reset();
    test_step_sequence();
    test_all_ones_limit();
    test_lower_limit();
    test_clear_and_reset();
    test_limit_zero();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
